// File: rtl/hpu_ctrl_regs.sv
// -----------------------------------------------------------------------------
// hpu_ctrl_regs
//
// AXI4-Lite slave holding the HPU control/config words and exposing read-only
// status words. Handles one transaction at a time. Writes honour WSTRB byte
// lanes and pulse a per-word write strobe. Accesses to an unmapped or
// read-only target answer SLVERR. Word 0 is the control word: bit 1 = run,
// bit 0 = gen. gen clears itself once the item-memory generator reports done.
//
// Address map: addr[ADDR_W-1] selects the region (0 = config, 1 = status).
// addr[ADDR_W-2:2] is the word index. addr[1:0] is ignored.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   s_axi_aw*/w*/b*   AXI-Lite write address / data / response channels
//   s_axi_ar*/r*      AXI-Lite read address / data channels (rdata registered)
//   gen_done          generation finished (level), clears gen
//   status_i          NUM_STATUS flat 32-bit status words
//   run, gen          control word bits 1 and 0
//   cfg_o             NUM_REGS flat 32-bit config words
//   wr_stb            one-cycle pulse per successfully written config word
// -----------------------------------------------------------------------------
module hpu_ctrl_regs #(
    parameter int ADDR_W     = 12,
    parameter int NUM_REGS   = 8,
    parameter int NUM_STATUS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          s_axi_awaddr,
    input  logic                       s_axi_awvalid,
    output logic                       s_axi_awready,
    input  logic [31:0]                s_axi_wdata,
    input  logic [3:0]                 s_axi_wstrb,
    input  logic                       s_axi_wvalid,
    output logic                       s_axi_wready,
    output logic [1:0]                 s_axi_bresp,
    output logic                       s_axi_bvalid,
    input  logic                       s_axi_bready,
    input  logic [ADDR_W-1:0]          s_axi_araddr,
    input  logic                       s_axi_arvalid,
    output logic                       s_axi_arready,
    output logic [31:0]                s_axi_rdata,
    output logic [1:0]                 s_axi_rresp,
    output logic                       s_axi_rvalid,
    input  logic                       s_axi_rready,
    input  logic                       gen_done,
    input  logic [NUM_STATUS*32-1:0]   status_i,
    output logic                       run,
    output logic                       gen,
    output logic [NUM_REGS*32-1:0]     cfg_o,
    output logic [NUM_REGS-1:0]        wr_stb
);

    localparam int IDX_W = ADDR_W - 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_AW    = 3'd1,
        ST_W     = 3'd2,
        ST_WRESP = 3'd3,
        ST_RD1   = 3'd4,
        ST_RD2   = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [ADDR_W-1:2]     r_awaddr;
    logic [ADDR_W-1:2]     r_araddr;
    logic [31:0]           r_wdata;
    logic [3:0]            r_wstrb;
    logic [31:0]           r_cfg [NUM_REGS];
    logic [NUM_REGS-1:0]   r_wr_stb;
    logic [1:0]            r_bresp;
    logic [1:0]            r_rresp;
    logic [31:0]           r_rdata;

    logic                  w_commit;
    logic [ADDR_W-1:2]     w_waddr;
    logic [31:0]           w_wdata;
    logic [3:0]            w_wstrb;
    logic [IDX_W-1:0]      w_widx;
    logic                  w_wr_ok;
    logic [NUM_REGS-1:0]   w_wr_onehot;
    logic [IDX_W-1:0]      w_ridx;
    logic                  w_rd_is_cfg;
    logic                  w_rd_is_st;
    logic [31:0]           w_rd_data;
    logic                  w_unused_addr_bits;

    // Byte-lane merge: lane b takes the new data only when its strobe is set.
    function automatic logic [31:0] f_lane_merge(input logic [31:0] old_v,
                                                 input logic [31:0] new_v,
                                                 input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return res;
    endfunction

    assign w_unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // Next-state decode. The write pair completes on the transition into WRESP.
    // The half that arrived earlier comes from the capture registers.
    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        w_waddr     = s_axi_awaddr[ADDR_W-1:2];
        w_wdata     = s_axi_wdata;
        w_wstrb     = s_axi_wstrb;
        case (r_state)
            ST_IDLE: begin
                if (s_axi_awvalid && s_axi_wvalid) begin
                    w_state_nxt = ST_WRESP;
                    w_commit    = 1'b1;
                end else if (s_axi_awvalid) begin
                    w_state_nxt = ST_AW;
                end else if (s_axi_wvalid) begin
                    w_state_nxt = ST_W;
                end else if (s_axi_arvalid) begin
                    w_state_nxt = ST_RD1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_AW: begin
                w_waddr = r_awaddr;
                if (s_axi_wvalid) begin
                    w_state_nxt = ST_WRESP;
                    w_commit    = 1'b1;
                end else begin
                    w_state_nxt = ST_AW;
                end
            end
            ST_W: begin
                w_wdata = r_wdata;
                w_wstrb = r_wstrb;
                if (s_axi_awvalid) begin
                    w_state_nxt = ST_WRESP;
                    w_commit    = 1'b1;
                end else begin
                    w_state_nxt = ST_W;
                end
            end
            ST_WRESP: begin
                if (s_axi_bready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WRESP;
                end
            end
            ST_RD1: begin
                w_state_nxt = ST_RD2;
            end
            ST_RD2: begin
                if (s_axi_rready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RD2;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_widx  = w_waddr[ADDR_W-2:2];
    assign w_wr_ok = !w_waddr[ADDR_W-1] && (32'(w_widx) < NUM_REGS);

    // One-hot decode of the write index, used for the write strobe.
    always_comb begin
        w_wr_onehot = {NUM_REGS{1'b0}};
        for (int k = 0; k < NUM_REGS; k++) begin
            w_wr_onehot[k] = (32'(w_widx) == k);
        end
    end

    assign w_ridx      = r_araddr[ADDR_W-2:2];
    assign w_rd_is_cfg = !r_araddr[ADDR_W-1] && (32'(w_ridx) < NUM_REGS);
    assign w_rd_is_st  = r_araddr[ADDR_W-1] && (32'(w_ridx) < NUM_STATUS);

    // Read mux: OR of the single selected word; unmapped addresses yield zero.
    always_comb begin
        w_rd_data = 32'h0000_0000;
        for (int k = 0; k < NUM_REGS; k++) begin
            w_rd_data = w_rd_data |
                        ((w_rd_is_cfg && (32'(w_ridx) == k)) ? r_cfg[k] : 32'h0000_0000);
        end
        for (int k = 0; k < NUM_STATUS; k++) begin
            w_rd_data = w_rd_data |
                        ((w_rd_is_st && (32'(w_ridx) == k)) ? status_i[32*k +: 32] : 32'h0000_0000);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture whichever address/data half is accepted while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_awaddr <= {(ADDR_W-2){1'b0}};
            r_wdata  <= 32'h0000_0000;
            r_wstrb  <= 4'h0;
            r_araddr <= {(ADDR_W-2){1'b0}};
        end else if (r_state == ST_IDLE) begin
            if (s_axi_awvalid) begin
                r_awaddr <= s_axi_awaddr[ADDR_W-1:2];
            end else begin
                r_awaddr <= r_awaddr;
            end
            if (s_axi_wvalid) begin
                r_wdata <= s_axi_wdata;
                r_wstrb <= s_axi_wstrb;
            end else begin
                r_wdata <= r_wdata;
                r_wstrb <= r_wstrb;
            end
            if (s_axi_arvalid) begin
                r_araddr <= s_axi_araddr[ADDR_W-1:2];
            end else begin
                r_araddr <= r_araddr;
            end
        end else begin
            r_awaddr <= r_awaddr;
            r_wdata  <= r_wdata;
            r_wstrb  <= r_wstrb;
            r_araddr <= r_araddr;
        end
    end

    // Config words. A commit to word 0 wins over the gen self-clear on the
    // same edge, and only bits [1:0] of word 0 are storable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                r_cfg[k] <= 32'h0000_0000;
            end
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (w_commit && w_wr_ok && (32'(w_widx) == k)) begin
                    if (k == 0) begin
                        r_cfg[k] <= f_lane_merge(r_cfg[k], w_wdata, w_wstrb) & 32'h0000_0003;
                    end else begin
                        r_cfg[k] <= f_lane_merge(r_cfg[k], w_wdata, w_wstrb);
                    end
                end else if ((k == 0) && r_cfg[k][0] && gen_done) begin
                    r_cfg[k] <= r_cfg[k] & 32'hFFFF_FFFE;
                end else begin
                    r_cfg[k] <= r_cfg[k];
                end
            end
        end
    end

    // Write response code and the strobe, which is high for the first WRESP cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bresp  <= 2'b00;
            r_wr_stb <= {NUM_REGS{1'b0}};
        end else if (w_commit) begin
            r_bresp  <= w_wr_ok ? 2'b00 : 2'b10;
            r_wr_stb <= w_wr_ok ? w_wr_onehot : {NUM_REGS{1'b0}};
        end else begin
            r_bresp  <= r_bresp;
            r_wr_stb <= {NUM_REGS{1'b0}};
        end
    end

    // Read data is loaded leaving RD1 and stays frozen while RD2 waits for rready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= 32'h0000_0000;
            r_rresp <= 2'b00;
        end else if (r_state == ST_RD1) begin
            r_rdata <= w_rd_data;
            r_rresp <= (w_rd_is_cfg || w_rd_is_st) ? 2'b00 : 2'b10;
        end else begin
            r_rdata <= r_rdata;
            r_rresp <= r_rresp;
        end
    end

    assign s_axi_awready = (r_state == ST_IDLE) || (r_state == ST_W);
    assign s_axi_wready  = (r_state == ST_IDLE) || (r_state == ST_AW);
    assign s_axi_arready = (r_state == ST_IDLE);
    assign s_axi_bvalid  = (r_state == ST_WRESP);
    assign s_axi_rvalid  = (r_state == ST_RD2);
    assign s_axi_bresp   = r_bresp;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rdata   = r_rdata;
    assign wr_stb        = r_wr_stb;
    assign run           = r_cfg[0][1];
    assign gen           = r_cfg[0][0];

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cfg_out
        assign cfg_o[32*g +: 32] = r_cfg[g];
    end

endmodule

// File: tb/tb_hpu_ctrl_regs.sv
// -----------------------------------------------------------------------------
// tb_hpu_ctrl_regs
//
// Directed scenarios followed by randomized AXI-Lite traffic. A transaction-
// level model keeps the expected config words and the expected response
// channel state. One negedge process compares the DUT against it every cycle.
// -----------------------------------------------------------------------------
module tb_hpu_ctrl_regs;

    localparam int ADDR_W     = 12;
    localparam int NUM_REGS   = 8;
    localparam int NUM_STATUS = 4;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [ADDR_W-1:0]         s_axi_awaddr = '0;
    logic                      s_axi_awvalid = 1'b0;
    logic                      s_axi_awready;
    logic [31:0]               s_axi_wdata = '0;
    logic [3:0]                s_axi_wstrb = '0;
    logic                      s_axi_wvalid = 1'b0;
    logic                      s_axi_wready;
    logic [1:0]                s_axi_bresp;
    logic                      s_axi_bvalid;
    logic                      s_axi_bready = 1'b0;
    logic [ADDR_W-1:0]         s_axi_araddr = '0;
    logic                      s_axi_arvalid = 1'b0;
    logic                      s_axi_arready;
    logic [31:0]               s_axi_rdata;
    logic [1:0]                s_axi_rresp;
    logic                      s_axi_rvalid;
    logic                      s_axi_rready = 1'b0;
    logic                      gen_done = 1'b0;
    logic [NUM_STATUS*32-1:0]  status_i = '0;
    logic                      run;
    logic                      gen;
    logic [NUM_REGS*32-1:0]    cfg_o;
    logic [NUM_REGS-1:0]       wr_stb;

    hpu_ctrl_regs #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .NUM_STATUS(NUM_STATUS)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .gen_done(gen_done),
        .status_i(status_i), .run(run), .gen(gen), .cfg_o(cfg_o), .wr_stb(wr_stb)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0]          m_cfg [NUM_REGS];
    logic [NUM_REGS-1:0]  exp_wr_stb = '0;
    logic                 exp_bvalid = 1'b0;
    logic [1:0]           exp_bresp  = 2'b00;
    logic                 exp_rvalid = 1'b0;
    logic [31:0]          exp_rdata  = '0;
    logic [1:0]           exp_rresp  = 2'b00;

    // events announced by the driver for the coming clock edge
    logic                 ev_commit = 1'b0, ev_bdone = 1'b0, ev_rd_load = 1'b0, ev_rdone = 1'b0;
    logic [ADDR_W-1:0]    ev_waddr = '0, ev_raddr = '0;
    logic [31:0]          ev_wdata = '0;
    logic [3:0]           ev_wstrb = '0;

    int gd_mode = 0;   // 0: gen_done low, 1: high, 2: random
    bit st_rand = 1'b0;

    function automatic bit cfg_hit(input logic [ADDR_W-1:0] a);
        return int'(a) < NUM_REGS * 4;
    endfunction

    function automatic bit st_hit(input logic [ADDR_W-1:0] a);
        return (int'(a) >= 2048) && ((int'(a) - 2048) < NUM_STATUS * 4);
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] o, input logic [31:0] d,
                                               input logic [3:0] s);
        logic [31:0] m = 32'h0;
        for (int b = 0; b < 4; b++) if (s[b]) m = m | (32'hFF << (8 * b));
        return (o & ~m) | (d & m);
    endfunction

    function automatic logic [31:0] rd_value(input logic [ADDR_W-1:0] a);
        logic [31:0] v = 32'h0;
        if (cfg_hit(a)) begin
            for (int k = 0; k < NUM_REGS; k++) if (int'(a) / 4 == k) v = m_cfg[k];
        end else if (st_hit(a)) begin
            v = status_i[32 * ((int'(a) - 2048) / 4) +: 32];
        end
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_REGS; k++) m_cfg[k] <= 32'h0;
            exp_wr_stb <= '0;
            exp_bvalid <= 1'b0;
            exp_bresp  <= 2'b00;
            exp_rvalid <= 1'b0;
            exp_rdata  <= 32'h0;
            exp_rresp  <= 2'b00;
        end else begin
            if (ev_commit) begin
                exp_bvalid <= 1'b1;
                exp_bresp  <= cfg_hit(ev_waddr) ? 2'b00 : 2'b10;
                exp_wr_stb <= cfg_hit(ev_waddr) ? NUM_REGS'(1 << (int'(ev_waddr) / 4)) : '0;
            end else begin
                exp_wr_stb <= '0;
                if (ev_bdone) exp_bvalid <= 1'b0;
            end
            for (int k = 0; k < NUM_REGS; k++) begin
                if (ev_commit && cfg_hit(ev_waddr) && (int'(ev_waddr) / 4 == k))
                    m_cfg[k] <= (k == 0) ? (lane_merge(m_cfg[k], ev_wdata, ev_wstrb) & 32'h3)
                                         : lane_merge(m_cfg[k], ev_wdata, ev_wstrb);
                else if (k == 0 && m_cfg[0][0] && gen_done)
                    m_cfg[0] <= m_cfg[0] & ~32'h1;
            end
            if (ev_rd_load) begin
                exp_rvalid <= 1'b1;
                exp_rdata  <= rd_value(ev_raddr);
                exp_rresp  <= (cfg_hit(ev_raddr) || st_hit(ev_raddr)) ? 2'b00 : 2'b10;
            end else if (ev_rdone) begin
                exp_rvalid <= 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [NUM_REGS*32-1:0] chk_flat;
    always @(negedge clk) begin
        for (int k = 0; k < NUM_REGS; k++) chk_flat[32*k +: 32] = m_cfg[k];
        chk("cfg_o", cfg_o, chk_flat);
        chk("run", run, m_cfg[0][1]);
        chk("gen", gen, m_cfg[0][0]);
        chk("wr_stb", wr_stb, exp_wr_stb);
        chk("bvalid", s_axi_bvalid, exp_bvalid);
        chk("rvalid", s_axi_rvalid, exp_rvalid);
        if (exp_bvalid) chk("bresp", s_axi_bresp, exp_bresp);
        if (exp_rvalid) begin
            chk("rdata", s_axi_rdata, exp_rdata);
            chk("rresp", s_axi_rresp, exp_rresp);
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(negedge clk);
        #1;
        ev_commit = 1'b0; ev_bdone = 1'b0; ev_rd_load = 1'b0; ev_rdone = 1'b0;
        case (gd_mode)
            0: gen_done = 1'b0;
            1: gen_done = 1'b1;
            default: gen_done = ($urandom_range(0, 3) == 0);
        endcase
        if (st_rand) for (int k = 0; k < NUM_STATUS; k++) status_i[32*k +: 32] = $urandom;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly,
                            input int b_dly, input bit force_gd,
                            output logic [1:0] bresp_o, output logic gen_o, output int stb_cnt);
        int last = (aw_dly > w_dly) ? aw_dly : w_dly;
        stb_cnt = 0;
        bresp_o = 2'b00;
        gen_o   = 1'b0;
        for (int c = 0; c <= last; c++) begin
            s_axi_awvalid = (c == aw_dly);
            s_axi_awaddr  = (c == aw_dly) ? addr : ADDR_W'($urandom);
            s_axi_wvalid  = (c == w_dly);
            s_axi_wdata   = (c == w_dly) ? data : $urandom;
            s_axi_wstrb   = (c == w_dly) ? strb : 4'($urandom);
            if (c == aw_dly) chk("awready", s_axi_awready, 1'b1);
            if (c == w_dly)  chk("wready", s_axi_wready, 1'b1);
            if (c > 0 && wr_stb != '0) stb_cnt++;
            if (c == last) begin
                ev_commit = 1'b1; ev_waddr = addr; ev_wdata = data; ev_wstrb = strb;
                if (force_gd) gen_done = 1'b1;
            end
            tick();
        end
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        for (int k = 0; k <= b_dly; k++) begin
            if (k == 0) begin
                bresp_o = s_axi_bresp;
                gen_o   = gen;
            end
            if (wr_stb != '0) stb_cnt++;
            s_axi_bready = (k == b_dly);
            ev_bdone     = (k == b_dly);
            tick();
        end
        s_axi_bready = 1'b0;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] addr, input int r_dly,
                           output logic [31:0] rdata_o, output logic [1:0] rresp_o);
        rdata_o = 32'h0;
        rresp_o = 2'b00;
        s_axi_arvalid = 1'b1;
        s_axi_araddr  = addr;
        chk("arready", s_axi_arready, 1'b1);
        tick();
        s_axi_arvalid = 1'b0;
        s_axi_araddr  = ADDR_W'($urandom);
        ev_rd_load = 1'b1;
        ev_raddr   = addr;
        tick();
        for (int k = 0; k <= r_dly; k++) begin
            if (k == 0) begin
                rdata_o = s_axi_rdata;
                rresp_o = s_axi_rresp;
            end
            s_axi_rready = (k == r_dly);
            ev_rdone     = (k == r_dly);
            tick();
        end
        s_axi_rready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    logic [1:0]  br, rr;
    logic        g;
    int          sc;
    logic [31:0] rd;

    initial begin
        #21;
        chk("rst_cfg_o", cfg_o, '0);
        chk("rst_run_gen", {run, gen}, 2'b00);
        chk("rst_wr_stb", wr_stb, '0);
        chk("rst_valids", {s_axi_bvalid, s_axi_rvalid}, 2'b00);
        chk("rst_resps", {s_axi_bresp, s_axi_rresp, s_axi_rdata}, 36'h0);
        rst = 1'b0;
        tick();
        chk("idle_readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);

        // 1: simultaneous AW+W to the control word, then read back
        do_write(12'h000, 32'h3, 4'hF, 0, 0, 0, 1'b0, br, g, sc);
        chk("t1_bresp", br, 2'b00);
        chk("t1_gen_at_resp", g, 1'b1);
        chk("t1_stb_pulses", sc, 1);
        do_read(12'h000, 0, rd, rr);
        chk("t1_rdata", rd, 32'h3);

        // 2: single-lane write into a populated word
        do_write(12'h008, 32'h11223344, 4'hF, 0, 0, 0, 1'b0, br, g, sc);
        do_write(12'h008, 32'hAABBCCDD, 4'b0010, 0, 0, 0, 1'b0, br, g, sc);
        do_read(12'h008, 1, rd, rr);
        chk("t2_rdata", rd, 32'h1122CC44);
        chk("t2_cfg_w2", cfg_o[95:64], 32'h1122CC44);

        // 3: W first, AW three cycles later, bready held off
        do_write(12'h00C, 32'hCAFE0001, 4'hF, 3, 0, 4, 1'b0, br, g, sc);
        chk("t3_stb_pulses", sc, 1);
        chk("t3_cfg_w3", cfg_o[127:96], 32'hCAFE0001);

        // 4: status read, unmapped read, write to read-only region
        status_i = '0;
        status_i[63:32] = 32'hDEADBEEF;
        do_read(12'h804, 0, rd, rr);
        chk("t4_st_rdata", rd, 32'hDEADBEEF);
        chk("t4_st_rresp", rr, 2'b00);
        do_read(12'h020, 0, rd, rr);
        chk("t4_bad_rdata", rd, 32'h0);
        chk("t4_bad_rresp", rr, 2'b10);
        do_write(12'h800, 32'h12345678, 4'hF, 0, 0, 0, 1'b0, br, g, sc);
        chk("t4_ro_bresp", br, 2'b10);
        chk("t4_ro_stb", sc, 0);

        // 5: gen self-clear, then word-0 commit racing with gen_done
        do_write(12'h000, 32'h3, 4'hF, 0, 0, 0, 1'b0, br, g, sc);
        gd_mode = 1;
        tick();
        tick();
        chk("t5_gen_cleared", gen, 1'b0);
        chk("t5_run_kept", run, 1'b1);
        gd_mode = 0;
        tick();
        do_write(12'h000, 32'h3, 4'hF, 0, 0, 0, 1'b0, br, g, sc);
        do_write(12'h000, 32'h3, 4'hF, 1, 0, 0, 1'b1, br, g, sc);
        chk("t5_commit_wins", g, 1'b1);

        // randomized traffic
        gd_mode = 2;
        st_rand = 1'b1;
        for (int i = 0; i < 250; i++) begin
            logic [ADDR_W-1:0] a;
            int d1, d2;
            a  = ($urandom_range(0, 3) == 0) ? ADDR_W'(12'h800 + $urandom_range(0, 63))
                                             : ADDR_W'($urandom_range(0, 63));
            d1 = $urandom_range(0, 3);
            d2 = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 0) begin
                case ($urandom_range(0, 2))
                    0: do_write(a, $urandom, 4'($urandom), 0, 0, d2, 1'b0, br, g, sc);
                    1: do_write(a, $urandom, 4'($urandom), d1, 0, d2, 1'b0, br, g, sc);
                    default: do_write(a, $urandom, 4'($urandom), 0, d1, d2, 1'b0, br, g, sc);
                endcase
            end else begin
                do_read(a, d1, rd, rr);
            end
            repeat ($urandom_range(0, 2)) tick();
        end

        // 6: asynchronous reset while a read response is pending
        gd_mode = 0;
        st_rand = 1'b0;
        tick();
        do_write(12'h000, 32'h3, 4'hF, 0, 0, 0, 1'b0, br, g, sc);
        do_write(12'h004, 32'h0000FFFF, 4'hF, 0, 0, 0, 1'b0, br, g, sc);
        s_axi_arvalid = 1'b1;
        s_axi_araddr  = 12'h004;
        tick();
        s_axi_arvalid = 1'b0;
        ev_rd_load = 1'b1;
        ev_raddr   = 12'h004;
        tick();
        chk("t6_rvalid_before", s_axi_rvalid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rvalid_async", s_axi_rvalid, 1'b0);
        chk("t6_run_gen_async", {run, gen}, 2'b00);
        chk("t6_cfg_async", cfg_o, '0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        tick();
        chk("t6_arready_after", s_axi_arready, 1'b1);
        chk("t6_awready_after", s_axi_awready, 1'b1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
